// File: rtl/rf_pkg.sv
// Shared constants and types for the parametrised register file with scoreboard.
// Optional same-cycle write-to-read bypass is enabled with the RF_BYPASS_EN macro.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: data/busy select, hardwired-zero register 0,
// and (with RF_BYPASS_EN defined) forwarding of a same-cycle write.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
`ifdef RF_BYPASS_EN
    input  logic              byp_we,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
    input  logic              byp_rsv,
    input  logic [ADDR_W-1:0] byp_rsv_addr,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              busy [2**ADDR_W],
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic is_zero;
    assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));

    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
`ifdef RF_BYPASS_EN
        // A reserve in the same cycle names a newer producer, so busy stays set.
        if (byp_we && (byp_addr == rd_addr)) begin
            rd_data = byp_data;
            rd_busy = byp_rsv && (byp_rsv_addr == rd_addr);
        end
`endif
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/rf_param_sb.sv
// Parametrised register file with per-register pending-write bits and a
// sequential clear sweep. Define RF_BYPASS_EN for same-cycle write forwarding.
module rf_param_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_Read_reg1,
    input  logic [ADDR_W-1:0] i_Read_reg2,
    output logic [DATA_W-1:0] o_Read_data1,
    output logic [DATA_W-1:0] o_Read_data2,
    output logic              o_Busy1,
    output logic              o_Busy2,
    input  logic              i_RegWrite,
    input  logic [ADDR_W-1:0] i_Write_reg,
    input  logic [DATA_W-1:0] i_Write_data,
    input  logic              i_Reserve,
    input  logic [ADDR_W-1:0] i_Reserve_reg,
    input  logic              i_clear,
    output logic              o_clr_busy
);

    localparam int                NREG     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    rf_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              clr_busy_reg;
    logic [DATA_W-1:0] regs_reg [NREG];
    logic              busy_reg [NREG];

    logic idle;
    logic sweeping;
    logic wr_en;
    logic rsv_en;

    assign idle     = (state_reg == RF_IDLE);
    assign sweeping = (state_reg == RF_CLEAR);
    // Register 0 drops writes and reserves when hardwired to zero.
    assign wr_en  = i_RegWrite && idle &&
                    !((ZERO_REG != 0) && (i_Write_reg == ADDR_W'(REG_ZERO)));
    assign rsv_en = i_Reserve && idle &&
                    !((ZERO_REG != 0) && (i_Reserve_reg == ADDR_W'(REG_ZERO)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= RF_IDLE;
            cnt_reg      <= '0;
            clr_busy_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clr_busy_reg <= (state_next == RF_CLEAR);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RF_IDLE: begin
                cnt_next = '0;
                if (i_clear) begin
                    state_next = RF_CLEAR;
                end
            end
            RF_CLEAR: begin
                // Counter wraps naturally to 0 after the last register.
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = RF_IDLE;
                end
            end
            default: begin
                state_next = RF_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_clr_busy = clr_busy_reg;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic hit_wr;
            logic hit_rsv;
            logic hit_clr;

            assign hit_wr  = wr_en  && (i_Write_reg   == ADDR_W'(gi));
            assign hit_rsv = rsv_en && (i_Reserve_reg == ADDR_W'(gi));
            assign hit_clr = sweeping && (cnt_reg == ADDR_W'(gi));

            always_ff @(posedge i_clk) begin
                if (i_rst || hit_clr) begin
                    regs_reg[gi] <= '0;
                end else if (hit_wr) begin
                    regs_reg[gi] <= i_Write_data;
                end
            end

            // Reserve beats write: the reserving instruction is the newer producer.
            always_ff @(posedge i_clk) begin
                if (i_rst || hit_clr) begin
                    busy_reg[gi] <= 1'b0;
                end else if (hit_rsv) begin
                    busy_reg[gi] <= 1'b1;
                end else if (hit_wr) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
`ifdef RF_BYPASS_EN
        .byp_we       (wr_en),
        .byp_addr     (i_Write_reg),
        .byp_data     (i_Write_data),
        .byp_rsv      (rsv_en),
        .byp_rsv_addr (i_Reserve_reg),
`endif
        .rd_addr      (i_Read_reg1),
        .regs         (regs_reg),
        .busy         (busy_reg),
        .rd_data      (o_Read_data1),
        .rd_busy      (o_Busy1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd2 (
`ifdef RF_BYPASS_EN
        .byp_we       (wr_en),
        .byp_addr     (i_Write_reg),
        .byp_data     (i_Write_data),
        .byp_rsv      (rsv_en),
        .byp_rsv_addr (i_Reserve_reg),
`endif
        .rd_addr      (i_Read_reg2),
        .regs         (regs_reg),
        .busy         (busy_reg),
        .rd_data      (o_Read_data2),
        .rd_busy      (o_Busy2)
    );

endmodule

// File: tb/tb_rf_param_sb.sv
// Scoreboard bench for rf_param_sb: stimulus queues expected read results,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_rf_param_sb;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  i_Read_reg1, i_Read_reg2;
    logic [31:0] o_Read_data1, o_Read_data2;
    logic        o_Busy1, o_Busy2;
    logic        i_RegWrite;
    logic [4:0]  i_Write_reg;
    logic [31:0] i_Write_data;
    logic        i_Reserve;
    logic [4:0]  i_Reserve_reg;
    logic        i_clear;
    logic        o_clr_busy;

    rf_param_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_Read_reg1  (i_Read_reg1),
        .i_Read_reg2  (i_Read_reg2),
        .o_Read_data1 (o_Read_data1),
        .o_Read_data2 (o_Read_data2),
        .o_Busy1      (o_Busy1),
        .o_Busy2      (o_Busy2),
        .i_RegWrite   (i_RegWrite),
        .i_Write_reg  (i_Write_reg),
        .i_Write_data (i_Write_data),
        .i_Reserve    (i_Reserve),
        .i_Reserve_reg(i_Reserve_reg),
        .i_clear      (i_clear),
        .o_clr_busy   (o_clr_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       nm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        cb;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    // Monitor: compares the DUT outputs against the oldest expectation.
    always @(negedge i_clk) begin
        if (chk_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL no_expectation: DUT sampled with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_Read_data1 !== e.d1 || o_Read_data2 !== e.d2 ||
                    o_Busy1 !== e.b1 || o_Busy2 !== e.b2 || o_clr_busy !== e.cb) begin
                    n_bad++;
                    $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b clr=%b, need d1=%h d2=%h b1=%b b2=%b clr=%b",
                             e.nm, o_Read_data1, o_Read_data2, o_Busy1, o_Busy2, o_clr_busy,
                             e.d1, e.d2, e.b1, e.b2, e.cb);
                end else begin
                    $display("[%0t] ok %s: d1=%h d2=%h b1=%b b2=%b clr=%b",
                             $time, e.nm, o_Read_data1, o_Read_data2, o_Busy1, o_Busy2, o_clr_busy);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Queue an expectation for the current cycle's outputs, then advance one edge.
    task automatic chk(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic eb1, input logic eb2, input logic ecb);
        exp_t e;
        i_Read_reg1 = a1;
        i_Read_reg2 = a2;
        e.nm = nm; e.d1 = e1; e.d2 = e2; e.b1 = eb1; e.b2 = eb2; e.cb = ecb;
        exp_q.push_back(e);
        chk_req = 1'b1;
        cyc();
        chk_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        i_RegWrite = 1'b1; i_Write_reg = a; i_Write_data = d;
        cyc();
        i_RegWrite = 1'b0;
    endtask

    task automatic rsv(input logic [4:0] a);
        i_Reserve = 1'b1; i_Reserve_reg = a;
        cyc();
        i_Reserve = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_Read_reg1 = '0; i_Read_reg2 = '0;
        i_RegWrite = 1'b0; i_Write_reg = '0; i_Write_data = '0;
        i_Reserve = 1'b0; i_Reserve_reg = '0; i_clear = 1'b0;
        cyc(); cyc();
        i_rst = 1'b0;

        // Reset state
        for (int i = 0; i < 32; i++) chk("reset", 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);

        // Basic write and hardwired zero
        wr(5, 32'hDEADBEEF);
        chk("wr_r5", 5, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        wr(0, 32'h1234);
        chk("wr_r0_dropped", 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);

        // Scoreboard
        rsv(7);
        chk("rsv_r7", 7, 5, 0, 32'hDEADBEEF, 1, 0, 0);
        wr(7, 32'h55);
        chk("wr_r7_clears", 7, 5, 32'h55, 32'hDEADBEEF, 0, 0, 0);
        i_Reserve = 1'b1; i_Reserve_reg = 9;
        wr(9, 32'hAA);
        i_Reserve = 1'b0;
        chk("rsv_wr_r9", 9, 7, 32'hAA, 32'h55, 1, 0, 0);
        i_Reserve = 1'b1; i_Reserve_reg = 10;
        wr(11, 32'hBB);
        i_Reserve = 1'b0;
        chk("rsv10_wr11", 10, 11, 0, 32'hBB, 1, 0, 0);
        rsv(0);
        chk("rsv_r0_dropped", 0, 10, 0, 0, 0, 1, 0);

        // Clear sweep with ignored write/reserve/clear mid-sweep
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        chk("loaded", 3, 31, 3, 31, 0, 0, 0);
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                i_RegWrite = 1'b1; i_Write_reg = 3; i_Write_data = 32'h77;
                chk("sweep_wr_ignored", 5'(k), 3, 32'(k), 0, 0, 0, 1);
                i_RegWrite = 1'b0;
            end else if (k == 12) begin
                i_Reserve = 1'b1; i_Reserve_reg = 2;
                chk("sweep_rsv_ignored", 5'(k), 31, 32'(k), 31, 0, 0, 1);
                i_Reserve = 1'b0;
            end else if (k == 15) begin
                i_clear = 1'b1;
                chk("sweep_clr_ignored", 5'(k), 31, 32'(k), 31, 0, 0, 1);
                i_clear = 1'b0;
            end else begin
                chk("sweep", 5'(k), 31, 32'(k), 31, 0, 0, 1);
            end
        end
        chk("sweep_done", 31, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) chk("cleared", 5'(i), 3, 0, 0, 0, 0, 0);

        // Reset in the middle of a sweep
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        for (int k = 0; k < 10; k++) chk("sweep2", 5'(k), 31, (k == 0) ? 0 : 32'h100 + 32'(k), 32'h11F, 0, 0, 1);
        i_rst = 1'b1;
        chk("rst_cycle", 10, 31, 32'h10A, 32'h11F, 0, 0, 1);
        i_rst = 1'b0;
        i_RegWrite = 1'b1; i_Write_reg = 6; i_Write_data = 32'h66;
        chk("after_rst", 10, 31, 0, 0, 0, 0, 0);
        i_RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) chk("rst_cleared", 5'(i), 6, (i == 6) ? 32'h66 : 0, 32'h66, 0, 0, 0);

        // Bypass behaviour
        wr(4, 32'h10);
        i_RegWrite = 1'b1; i_Write_reg = 4; i_Write_data = 32'h20;
`ifdef RF_BYPASS_EN
        chk("byp_same", 4, 4, 32'h20, 32'h20, 0, 0, 0);
`else
        chk("byp_same", 4, 4, 32'h10, 32'h10, 0, 0, 0);
`endif
        i_RegWrite = 1'b0;
        chk("byp_next", 4, 0, 32'h20, 0, 0, 0, 0);
        rsv(8);
        i_RegWrite = 1'b1; i_Write_reg = 8; i_Write_data = 32'h88;
`ifdef RF_BYPASS_EN
        chk("byp_busy", 8, 4, 32'h88, 32'h20, 0, 0, 0);
`else
        chk("byp_busy", 8, 4, 0, 32'h20, 1, 0, 0);
`endif
        i_RegWrite = 1'b0;
        chk("byp_busy_next", 8, 4, 32'h88, 32'h20, 0, 0, 0);
        i_RegWrite = 1'b1; i_Write_reg = 12; i_Write_data = 32'hCC;
        i_Reserve = 1'b1; i_Reserve_reg = 12;
`ifdef RF_BYPASS_EN
        chk("byp_rsv_wr", 12, 8, 32'hCC, 32'h88, 1, 0, 0);
`else
        chk("byp_rsv_wr", 12, 8, 0, 32'h88, 0, 0, 0);
`endif
        i_RegWrite = 1'b0; i_Reserve = 1'b0;
        chk("byp_rsv_wr_next", 12, 8, 32'hCC, 32'h88, 1, 0, 0);
        i_RegWrite = 1'b1; i_Write_reg = 0; i_Write_data = 32'hFFFF_FFFF;
        chk("byp_r0", 0, 0, 0, 0, 0, 0, 0);
        i_RegWrite = 1'b0;

        cyc(); cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
